instruction_fetch_unit: RTL and testbench

//  Producer side of the instruction-register interface: fetches 32-bit ARM words from RAM via MAR/MDR

---
 rtl/arm_pkg.sv | 17 +
 rtl/program_counter.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared types and defaults for the ARM instruction fetch path.
package arm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_MAR,
        ST_MEM_READ,
        ST_LOAD_IR,
        ST_PRESENT,
        ST_FAULT
    } fetch_state_e;

    localparam int          INSTR_BYTES         = 4;
    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
    localparam int          DEFAULT_MFC_TIMEOUT = 15;

endpackage

// File: rtl/program_counter.sv
// Program counter register: a branch load takes priority over the sequential word increment.
module program_counter
    import arm_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              incr,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (incr) begin
            pc <= pc + ADDR_W'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch FSM: drives MAR/RAM/MDR/IR strobes with the mfc handshake and hands words to the decoder.
module instruction_fetch_unit
    import arm_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                MFC_TIMEOUT = DEFAULT_MFC_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mar_en,
    output logic              ram_en,
    output logic              mdr_en,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mfc,
    output logic              instRegister_en,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_error
);

    localparam int             CNT_W    = $clog2(MFC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MFC_TIMEOUT - 1);

    fetch_state_e      state;
    fetch_state_e      state_nxt;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [DATA_W-1:0] mdr;
    logic              redirect_take;
    logic [ADDR_W-1:0] redirect_aligned;
    logic              pc_incr;

    // A fault can only be left through reset, so redirects are ignored there.
    assign redirect_take    = redirect && (state != ST_FAULT);
    assign redirect_aligned = redirect_addr & ~ADDR_W'(3);
    assign pc_incr          = (state == ST_PRESENT) && instr_ready;

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (redirect_take),
        .load_val (redirect_aligned),
        .incr     (pc_incr),
        .pc       (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_LOAD_MAR;
            end
            ST_LOAD_MAR: state_nxt = ST_MEM_READ;
            ST_MEM_READ: begin
                if (mfc) begin
                    state_nxt = ST_LOAD_IR;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_LOAD_IR: state_nxt = ST_PRESENT;
            ST_PRESENT: begin
                if (instr_ready) state_nxt = run ? ST_LOAD_MAR : ST_IDLE;
            end
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_IDLE;
        endcase
        // Redirect overrides any same-cycle mfc, timeout or accept.
        if (redirect_take) state_nxt = run ? ST_LOAD_MAR : ST_IDLE;
    end

    always_comb begin
        mar_en          = 1'b0;
        ram_en          = 1'b0;
        mdr_en          = 1'b0;
        instRegister_en = 1'b0;
        instr_valid     = 1'b0;
        fetch_error     = 1'b0;
        unique case (state)
            ST_LOAD_MAR: mar_en = 1'b1;
            ST_MEM_READ: begin
                ram_en = 1'b1;
                mdr_en = 1'b1;
            end
            ST_LOAD_IR:  instRegister_en = 1'b1;
            ST_PRESENT:  instr_valid = 1'b1;
            ST_FAULT:    fetch_error = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr    <= '0;
            instruction <= '0;
            tmo_cnt     <= '0;
        end else begin
            if (state == ST_LOAD_MAR) mem_addr <= pc;
            tmo_cnt <= (state == ST_MEM_READ) ? tmo_cnt + CNT_W'(1) : '0;
            if ((state == ST_LOAD_IR) && !redirect_take) instruction <= mdr;
        end
    end

    // MDR only matters once captured; a late mfc from an aborted read never reaches it.
    always_ff @(posedge clk) begin
        if ((state == ST_MEM_READ) && mfc && !redirect_take) mdr <= mem_rdata;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: fetch sequencing, stalls, redirect, timeout, wrap and reset.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [31:0] mem_addr;
    logic        mar_en;
    logic        ram_en;
    logic        mdr_en;
    logic [31:0] mem_rdata;
    logic        mfc;
    logic        instRegister_en;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic        fetch_error;

    logic        auto_mfc;
    logic        force_mfc;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory answers in the first read cycle when auto_mfc is set.
    always_comb begin
        mfc       = (auto_mfc & ram_en) | force_mfc;
        mem_rdata = rdata;
    end

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .run             (run),
        .redirect        (redirect),
        .redirect_addr   (redirect_addr),
        .mem_addr        (mem_addr),
        .mar_en          (mar_en),
        .ram_en          (ram_en),
        .mdr_en          (mdr_en),
        .mem_rdata       (mem_rdata),
        .mfc             (mfc),
        .instRegister_en (instRegister_en),
        .instruction     (instruction),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .pc              (pc),
        .fetch_error     (fetch_error)
    );

    // Flags order: mar_en ram_en mdr_en instRegister_en instr_valid fetch_error
    function automatic logic [5:0] flags();
        return {mar_en, ram_en, mdr_en, instRegister_en, instr_valid, fetch_error};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; redirect = 1'b0; redirect_addr = '0;
        instr_ready = 1'b0; auto_mfc = 1'b0; force_mfc = 1'b0; rdata = '0;
        step();
        step();
        total++;
        if (flags() !== 6'b000000) begin
            bad++; $display("FAIL reset_flags: got %b want 000000", flags());
        end
        total++;
        if ({pc, mem_addr, instruction} !== 96'h0) begin
            bad++; $display("FAIL reset_regs: pc=%h mem_addr=%h instr=%h want all 0", pc, mem_addr, instruction);
        end
        reset = 1'b0;
        step();
        total++;
        if (flags() !== 6'b000000) begin
            bad++; $display("FAIL idle_no_run: got %b want 000000", flags());
        end
    endtask

    task automatic test_basic_fetch();
        logic [31:0] words [3] = '{32'hE082_1003, 32'hE3A0_0005, 32'hE1A0_F00E};
        run = 1'b1; instr_ready = 1'b1; auto_mfc = 1'b1;
        step();
        for (int w = 0; w < 3; w++) begin
            rdata = words[w];
            total++;
            if ({flags(), pc} !== {6'b100000, 32'(4 * w)}) begin
                bad++; $display("FAIL basic_mar w%0d: flags=%b pc=%h want 100000 %h", w, flags(), pc, 4 * w);
            end
            step();
            total++;
            if ({flags(), mem_addr} !== {6'b011000, 32'(4 * w)}) begin
                bad++; $display("FAIL basic_read w%0d: flags=%b addr=%h want 011000 %h", w, flags(), mem_addr, 4 * w);
            end
            step();
            total++;
            if (flags() !== 6'b000100) begin
                bad++; $display("FAIL basic_ir w%0d: flags=%b want 000100", w, flags());
            end
            step();
            total++;
            if ({flags(), instruction, pc} !== {6'b000010, words[w], 32'(4 * w)}) begin
                bad++; $display("FAIL basic_present w%0d: flags=%b instr=%h pc=%h want 000010 %h %h",
                                w, flags(), instruction, pc, words[w], 4 * w);
            end
            step();
        end
    endtask

    task automatic test_stall();
        // Entered in LOAD_MAR with pc=12
        instr_ready = 1'b0; rdata = 32'h1234_5678;
        step();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            rdata = 32'hFFFF_0000 + 32'(i);
            total++;
            if ({flags(), instruction, pc} !== {6'b000010, 32'h1234_5678, 32'd12}) begin
                bad++; $display("FAIL stall_hold c%0d: flags=%b instr=%h pc=%h want 000010 12345678 0000000c",
                                i, flags(), instruction, pc);
            end
            step();
        end
        instr_ready = 1'b1;
        step();
        total++;
        if ({flags(), pc} !== {6'b100000, 32'd16}) begin
            bad++; $display("FAIL stall_accept: flags=%b pc=%h want 100000 00000010", flags(), pc);
        end
    endtask

    task automatic test_redirect();
        // Entered in LOAD_MAR with pc=16; memory held silent
        auto_mfc = 1'b0; rdata = 32'hDEAD_BEEF;
        step();
        redirect = 1'b1; redirect_addr = 32'h0000_0103; force_mfc = 1'b1;
        step();
        redirect = 1'b0;
        total++;
        if ({flags(), pc} !== {6'b100000, 32'h100}) begin
            bad++; $display("FAIL redir_target: flags=%b pc=%h want 100000 00000100", flags(), pc);
        end
        step();
        force_mfc = 1'b0; auto_mfc = 1'b1; rdata = 32'hE3A0_0001;
        total++;
        if ({flags(), mem_addr} !== {6'b011000, 32'h100}) begin
            bad++; $display("FAIL redir_mar_addr: flags=%b addr=%h want 011000 00000100", flags(), mem_addr);
        end
        step();
        step();
        total++;
        if ({flags(), instruction, pc} !== {6'b000010, 32'hE3A0_0001, 32'h100}) begin
            bad++; $display("FAIL redir_word: flags=%b instr=%h pc=%h want 000010 e3a00001 00000100",
                            flags(), instruction, pc);
        end
        // Redirect coinciding with accept: target wins, no +4
        redirect = 1'b1; redirect_addr = 32'h0000_0200;
        step();
        redirect = 1'b0;
        total++;
        if ({flags(), pc} !== {6'b100000, 32'h200}) begin
            bad++; $display("FAIL redir_vs_accept: flags=%b pc=%h want 100000 00000200", flags(), pc);
        end
    endtask

    task automatic test_timeout();
        // Entered in LOAD_MAR with pc=0x200
        auto_mfc = 1'b0;
        step();
        for (int i = 0; i < 15; i++) begin
            total++;
            if (flags() !== 6'b011000) begin
                bad++; $display("FAIL tmo_wait c%0d: flags=%b want 011000", i, flags());
            end
            step();
        end
        total++;
        if (flags() !== 6'b000001) begin
            bad++; $display("FAIL tmo_fault: flags=%b want 000001", flags());
        end
        force_mfc = 1'b1; redirect = 1'b1; redirect_addr = 32'h0000_0400;
        step();
        step();
        force_mfc = 1'b0; redirect = 1'b0;
        total++;
        if ({flags(), pc} !== {6'b000001, 32'h200}) begin
            bad++; $display("FAIL tmo_sticky: flags=%b pc=%h want 000001 00000200", flags(), pc);
        end
        reset = 1'b1;
        step();
        reset = 1'b0; run = 1'b0;
        total++;
        if ({flags(), pc, mem_addr, instruction} !== {6'b000000, 96'h0}) begin
            bad++; $display("FAIL tmo_reset: flags=%b pc=%h addr=%h instr=%h want 000000 0 0 0",
                            flags(), pc, mem_addr, instruction);
        end
        step();
        total++;
        if (flags() !== 6'b000000) begin
            bad++; $display("FAIL tmo_idle: flags=%b want 000000", flags());
        end
    endtask

    task automatic test_wrap_and_stop();
        auto_mfc = 1'b1; instr_ready = 1'b1; rdata = 32'hE12F_FF1E;
        run = 1'b1; redirect = 1'b1; redirect_addr = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        total++;
        if ({flags(), pc} !== {6'b100000, 32'hFFFF_FFFC}) begin
            bad++; $display("FAIL wrap_load: flags=%b pc=%h want 100000 fffffffc", flags(), pc);
        end
        step();
        run = 1'b0;
        step();
        step();
        total++;
        if ({flags(), instruction, pc} !== {6'b000010, 32'hE12F_FF1E, 32'hFFFF_FFFC}) begin
            bad++; $display("FAIL wrap_present: flags=%b instr=%h pc=%h want 000010 e12fff1e fffffffc",
                            flags(), instruction, pc);
        end
        step();
        total++;
        if ({flags(), pc} !== {6'b000000, 32'h0}) begin
            bad++; $display("FAIL wrap_idle: flags=%b pc=%h want 000000 00000000", flags(), pc);
        end
        step();
        total++;
        if (flags() !== 6'b000000) begin
            bad++; $display("FAIL stop_stays_idle: flags=%b want 000000", flags());
        end
    endtask

    task automatic test_reset_midflight();
        auto_mfc = 1'b1; instr_ready = 1'b0; rdata = 32'h5A5A_0001;
        run = 1'b1; redirect = 1'b1; redirect_addr = 32'h0000_0040;
        step();
        redirect = 1'b0;
        step();
        step();
        total++;
        if ({flags(), pc} !== {6'b000100, 32'h40}) begin
            bad++; $display("FAIL rst_ir_pre: flags=%b pc=%h want 000100 00000040", flags(), pc);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({flags(), pc, mem_addr, instruction} !== {6'b000000, 96'h0}) begin
            bad++; $display("FAIL rst_in_ir: flags=%b pc=%h addr=%h instr=%h want 000000 0 0 0",
                            flags(), pc, mem_addr, instruction);
        end
        rdata = 32'hA5A5_A5A5; redirect = 1'b1; redirect_addr = 32'h0000_0080;
        step();
        redirect = 1'b0;
        step();
        step();
        step();
        total++;
        if ({flags(), instruction, pc} !== {6'b000010, 32'hA5A5_A5A5, 32'h80}) begin
            bad++; $display("FAIL rst_present_pre: flags=%b instr=%h pc=%h want 000010 a5a5a5a5 00000080",
                            flags(), instruction, pc);
        end
        reset = 1'b1;
        step();
        reset = 1'b0; run = 1'b0;
        total++;
        if ({flags(), pc, mem_addr, instruction} !== {6'b000000, 96'h0}) begin
            bad++; $display("FAIL rst_in_present: flags=%b pc=%h addr=%h instr=%h want 000000 0 0 0",
                            flags(), pc, mem_addr, instruction);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect();
        test_timeout();
        test_wrap_and_stop();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
